// File: rtl/dmadd_cmd_sequencer_if.sv
// Host command push and DMADD datapath control bundle for dmadd_cmd_sequencer.
// The master side is the host/bench; the slave side is the sequencer itself.
interface dmadd_cmd_sequencer_if #(
    parameter int DEPTH = 4
) ();
    localparam int LW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [11:0]   in_data;
    logic          in_ready;
    logic          abort;
    logic [3:0]    dm_index;
    logic [3:0]    dm_data;
    logic [1:0]    dm_insn;
    logic          dm_load;
    logic          dm_run;
    logic          busy;
    logic          run_done;
    logic [LW-1:0] level;

    modport master (
        output in_valid, in_data, abort,
        input  in_ready, dm_index, dm_data, dm_insn, dm_load, dm_run,
               busy, run_done, level
    );

    modport slave (
        input  in_valid, in_data, abort,
        output in_ready, dm_index, dm_data, dm_insn, dm_load, dm_run,
               busy, run_done, level
    );
endinterface

// File: rtl/dmadd_cmd_sequencer.sv
// Buffers packed 12-bit DMADD command words in a small FIFO and replays them
// as registered per-cycle datapath controls with back-to-back issue.
module dmadd_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    dmadd_cmd_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_WAIT} state_t;
    typedef enum logic [1:0] {OP_INIT, OP_LOAD, OP_RUN, OP_WAIT} op_t;

    typedef struct packed {
        logic       load;
        logic       run;
        logic [1:0] insn;
        logic [3:0] index;
        logic [3:0] data;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{load: 1'b0, run: 1'b0, insn: 2'b11,
                                  index: 4'd0, data: 4'd0};

    logic [11:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    state_t        state;
    logic [4:0]    cnt;
    ctl_t          ctl;
    logic          run_done_q;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          cmd_end;
    logic [11:0]   head;
    op_t           head_op;
    logic [1:0]    head_insn;
    logic [3:0]    head_index;
    logic [3:0]    head_data;

    assign full       = (level_q == LW'(DEPTH));
    assign empty      = (level_q == '0);
    assign bus.in_ready = !full && !bus.abort;
    assign push       = bus.in_valid && bus.in_ready;

    assign head       = mem[rd_ptr];
    assign head_op    = op_t'(head[11:10]);
    assign head_insn  = head[9:8];
    assign head_index = head[7:4];
    assign head_data  = head[3:0];

    always_comb begin
        cmd_end = 1'b1;
        case (state)
            S_RUN, S_WAIT: cmd_end = (cnt == 5'd0);
            default:       cmd_end = 1'b1;
        endcase
    end

    assign pop = cmd_end && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            state      <= S_IDLE;
            cnt        <= '0;
            ctl        <= CTL_IDLE;
            run_done_q <= 1'b0;
        end else if (bus.abort) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            state      <= S_IDLE;
            cnt        <= '0;
            ctl        <= CTL_IDLE;
            run_done_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level_q    <= level_q + LW'(push) - LW'(pop);
            run_done_q <= 1'b0;

            if (cmd_end) begin
                if (!empty) begin
                    // The popped word drives the outputs from this same edge,
                    // which is what gives gap-free back-to-back issue.
                    case (head_op)
                        OP_INIT: begin
                            state    <= S_ISSUE;
                            ctl.load <= 1'b0;
                            ctl.run  <= 1'b0;
                            ctl.insn <= head_insn;
                        end
                        OP_LOAD: begin
                            state <= S_ISSUE;
                            ctl   <= '{load: 1'b1, run: 1'b0, insn: head_insn,
                                       index: head_index, data: head_data};
                        end
                        OP_RUN: begin
                            state      <= S_RUN;
                            cnt        <= {1'b0, head_data};
                            ctl.load   <= 1'b0;
                            ctl.run    <= 1'b1;
                            ctl.insn   <= head_insn;
                            run_done_q <= (head_data == 4'd0);
                        end
                        default: begin
                            state <= S_WAIT;
                            cnt   <= {1'b0, head_data};
                            ctl   <= CTL_IDLE;
                        end
                    endcase
                end else begin
                    state <= S_IDLE;
                    ctl   <= CTL_IDLE;
                end
            end else begin
                cnt <= cnt - 5'd1;
                if (state == S_RUN && cnt == 5'd1) begin
                    run_done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.dm_load  = ctl.load;
    assign bus.dm_run   = ctl.run;
    assign bus.dm_insn  = ctl.insn;
    assign bus.dm_index = ctl.index;
    assign bus.dm_data  = ctl.data;
    assign bus.run_done = run_done_q;
    assign bus.level    = level_q;
    assign bus.busy     = (state != S_IDLE) || (level_q != '0);
endmodule

// File: tb/tb_dmadd_cmd_sequencer.sv
// Scoreboard bench for dmadd_cmd_sequencer: accepted words expand into
// per-cycle expected control vectors, compared as the datapath outputs appear.
module tb_dmadd_cmd_sequencer;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    dmadd_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();

    dmadd_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Vector layout: {load, run, insn[1:0], index[3:0], data[3:0], run_done}
    localparam logic [12:0] IDLE_VEC  = 13'b0_0_11_0000_0000_0;
    localparam logic [12:0] FULL_MASK = 13'h1FFF;
    localparam logic [12:0] INIT_MASK = 13'h1E01;

    typedef struct {
        logic [12:0] vec;
        logic [12:0] mask;
        int unsigned rdy;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [12:0] act;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned max_level = 0;
    logic        mon_en = 1'b0;
    logic [3:0]  held_idx = 4'd0;
    logic [3:0]  held_dat = 4'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [12:0] pack(input logic l, input logic r, input logic [1:0] insn,
                                         input logic [3:0] idx, input logic [3:0] dat,
                                         input logic done);
        return {l, r, insn, idx, dat, done};
    endfunction

    function automatic logic [12:0] observed();
        return pack(bus.dm_load, bus.dm_run, bus.dm_insn, bus.dm_index, bus.dm_data, bus.run_done);
    endfunction

    task automatic expand(input logic [11:0] w);
        exp_t        x;
        logic [1:0]  insn;
        logic [3:0]  idx;
        logic [3:0]  dat;
        insn  = w[9:8];
        idx   = w[7:4];
        dat   = w[3:0];
        x.rdy = cyc + 1;
        case (w[11:10])
            2'b00: begin
                x.vec  = pack(1'b0, 1'b0, insn, 4'd0, 4'd0, 1'b0);
                x.mask = INIT_MASK;
                sb.push_back(x);
            end
            2'b01: begin
                held_idx = idx;
                held_dat = dat;
                x.vec    = pack(1'b1, 1'b0, insn, idx, dat, 1'b0);
                x.mask   = FULL_MASK;
                sb.push_back(x);
            end
            2'b10: begin
                for (int k = 0; k <= int'(dat); k++) begin
                    x.vec  = pack(1'b0, 1'b1, insn, held_idx, held_dat, k == int'(dat));
                    x.mask = FULL_MASK;
                    sb.push_back(x);
                end
            end
            default: begin
                held_idx = 4'd0;
                held_dat = 4'd0;
                for (int k = 0; k <= int'(dat); k++) begin
                    x.vec  = IDLE_VEC;
                    x.mask = FULL_MASK;
                    sb.push_back(x);
                end
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            act = observed();
            if (sb.size() != 0 && sb[0].rdy <= cyc) begin
                e = sb.pop_front();
                check_eq("ctl", 32'(act & e.mask), 32'(e.vec));
                check_eq("busy_active", 32'(bus.busy), 32'd1);
            end else begin
                check_eq("idle", 32'(act), 32'(IDLE_VEC));
            end
            if (int'(bus.level) > int'(max_level)) max_level = int'(bus.level);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [11:0] w);
        int unsigned budget;
        budget       = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        #1;
        while (!bus.in_ready && budget < 100) begin
            check_eq("full_level", 32'(bus.level), 32'(DEPTH));
            @(posedge clk);
            #2;
            budget++;
        end
        if (!bus.in_ready) begin
            check_eq("send_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            #1;
        end else begin
            @(posedge clk);
            #1;
            expand(w);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int unsigned budget;
        budget = 0;
        while ((sb.size() != 0 || bus.busy) && budget < 400) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check_eq("drain_busy", 32'(bus.busy), 32'd0);
        check_eq("drain_sb", 32'(sb.size()), 32'd0);
        check_eq("drain_level", 32'(bus.level), 32'd0);
        held_idx = 4'd0;
        held_dat = 4'd0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 12'h000;
        bus.abort    = 1'b0;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        check_eq("rst_ctl", 32'(observed()), 32'(IDLE_VEC));
        check_eq("rst_level", 32'(bus.level), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Single LOAD
        send(12'h453);
        drain();

        // Back-to-back INIT, LOAD, RUN(2)
        send(12'h179);
        send(12'h6C6);
        send(12'hA02);
        drain();

        // WAIT(2) then LOAD then RUN(0)
        send(12'hC02);
        send(12'h4AB);
        send(12'h900);
        drain();

        // Backpressure: 6 words queued behind a RUN(15)
        max_level = 0;
        send(12'h80F);
        for (int i = 0; i < 6; i++) begin
            send({2'b01, 2'(i % 4), 4'(i + 1), 4'(15 - i)});
        end
        check_eq("max_level_full", max_level, 32'd4);
        drain();

        // Abort during a RUN with 3 queued words; push in abort cycle dropped
        send(12'h80A);
        send(12'h411);
        send(12'h522);
        send(12'h633);
        check_eq("pre_abort_level", 32'(bus.level), 32'd3);
        @(posedge clk);
        #1;
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 12'h4EE;
        #1;
        check_eq("abort_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        held_idx = 4'd0;
        held_dat = 4'd0;
        check_eq("abort_ctl", 32'(observed()), 32'(IDLE_VEC));
        check_eq("abort_level", 32'(bus.level), 32'd0);
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        repeat (4) begin @(posedge clk); #1; end
        check_eq("abort_level_after", 32'(bus.level), 32'd0);

        // Reset mid-command with a word queued
        send(12'h80C);
        send(12'h4F1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check_eq("midrst_ctl", 32'(observed()), 32'(IDLE_VEC));
        check_eq("midrst_level", 32'(bus.level), 32'd0);
        check_eq("midrst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check_eq("midrst_no_resume", 32'(bus.busy), 32'd0);

        // Wrap-around: 20 RUNs holding LOAD index/data, level 3<->4
        max_level = 0;
        send(12'h4A5);
        for (int i = 0; i < 20; i++) begin
            send({2'b10, 2'(i % 4), 4'h0, 4'(1 + i % 2)});
        end
        check_eq("max_level_wrap", max_level, 32'd4);
        drain();

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
